// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between the
// in-order WB stage and a long-latency unit (MDU: mul/div/load-miss).
// WB has priority; after MAX_WAIT consecutive MDU losses the arbiter spends
// one cycle in STARVE, stalling WB and granting the MDU.
// Optional feature macro: REGFILE_INIT_EN. When it is defined, an INIT sweep
// after reset writes 0 to x1..x31 before normal arbitration starts.
//
// Handshake semantics (valid/ready): the MDU raises mdu_valid with stable
// mdu_rd/mdu_data and keeps them until it sees mdu_ready. A transfer happens
// on the posedge where mdu_valid & mdu_ready are both high. mdu_ready never
// depends on anything but the current inputs and registered arbitration
// state. WB is not handshaked: wb_stall=1 means "this cycle's write did not
// happen, hold wb_rd/wb_data".
// The grant is combinational, so the winning write lands on the same posedge
// as its request. The FSM state is visible as state_q for debug binding.
module regfile_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              wb_stall,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]   mdu_data,
  output logic              mdu_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] rd,
  output logic [XLEN-1:0]   write_data,
  output logic              busy_init
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LOSS_LIMIT = CW'(MAX_WAIT - 1);

`ifdef REGFILE_INIT_EN
  typedef enum logic [1:0] {S_NORMAL = 2'd0, S_STARVE = 2'd1, S_INIT = 2'd2} state_t;
  localparam state_t RESET_STATE = S_INIT;
  logic [ADDR_W-1:0] init_ptr_q, init_ptr_d;
`else
  typedef enum logic [1:0] {S_NORMAL = 2'd0, S_STARVE = 2'd1} state_t;
  localparam state_t RESET_STATE = S_NORMAL;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          wb_req, mdu_req, mdu_hs;

  // x0 writes are discarded: a request to x0 is never a real write.
  assign wb_req  = wb_valid & (wb_rd != '0);
  assign mdu_req = mdu_valid & (mdu_rd != '0);

  // Arbitration state register; reset restarts from the reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
      wait_q  <= '0;
`ifdef REGFILE_INIT_EN
      init_ptr_q <= ADDR_W'(1);
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
`ifdef REGFILE_INIT_EN
      init_ptr_q <= init_ptr_d;
`endif
    end
  end

  // Grant decision, write-port mux and next-state logic.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    RegWrite   = 1'b0;
    rd         = wb_rd;
    write_data = wb_data;
    wb_stall   = 1'b0;
    mdu_ready  = 1'b0;
    busy_init  = 1'b0;
    mdu_hs     = 1'b0;
`ifdef REGFILE_INIT_EN
    init_ptr_d = init_ptr_q;
`endif
    if (!rst) begin
      case (state_q)
        S_NORMAL: begin
          if (wb_req) begin
            RegWrite  = 1'b1;
            // An x0 MDU result can retire alongside a WB write.
            mdu_ready = ~mdu_valid | (mdu_rd == '0);
          end else begin
            RegWrite   = mdu_req;
            rd         = mdu_rd;
            write_data = mdu_data;
            mdu_ready  = 1'b1;
          end
          mdu_hs = mdu_valid & mdu_ready;
          if (wb_req & mdu_req) begin
            if (wait_q == LOSS_LIMIT) begin
              state_d = S_STARVE;
              wait_d  = '0;
            end else begin
              wait_d = wait_q + CW'(1);
            end
          end else if (mdu_hs) begin
            wait_d = '0;
          end
        end
        S_STARVE: begin
          // One forced MDU slot; a dropped mdu_valid simply wastes it.
          wb_stall   = wb_valid;
          RegWrite   = mdu_req;
          rd         = mdu_rd;
          write_data = mdu_data;
          mdu_ready  = 1'b1;
          wait_d     = '0;
          state_d    = S_NORMAL;
        end
`ifdef REGFILE_INIT_EN
        S_INIT: begin
          RegWrite   = 1'b1;
          rd         = init_ptr_q;
          write_data = '0;
          busy_init  = 1'b1;
          wb_stall   = wb_valid;
          if (init_ptr_q == '1) begin
            state_d = S_NORMAL;
          end else begin
            init_ptr_d = init_ptr_q + ADDR_W'(1);
          end
        end
`endif
        default: state_d = S_NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus randomized traffic checked
// against a behavioural model of the arbitration rules (loss counting,
// forced MDU slot, optional init sweep) and a shadow register file.
module tb_regfile_wb_arbiter;

  localparam int XLEN     = 32;
  localparam int ADDR_W   = 5;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wb_valid = 1'b0;
  logic [ADDR_W-1:0] wb_rd = '0;
  logic [XLEN-1:0]   wb_data = '0;
  logic              wb_stall;
  logic              mdu_valid = 1'b0;
  logic [ADDR_W-1:0] mdu_rd = '0;
  logic [XLEN-1:0]   mdu_data = '0;
  logic              mdu_ready;
  logic              RegWrite;
  logic [ADDR_W-1:0] rd;
  logic [XLEN-1:0]   write_data;
  logic              busy_init;

  int tests_run = 0;
  int tests_failed = 0;

  regfile_wb_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .RegWrite(RegWrite), .rd(rd), .write_data(write_data), .busy_init(busy_init)
  );

  // Clock / reset block
  always #5 clk = ~clk;

`ifdef REGFILE_INIT_EN
  localparam int INIT_CYCLES = 31;
`else
  localparam int INIT_CYCLES = 0;
`endif

  // Behavioural model state
  int                losses;
  bit                forced;
  int                init_left;
  bit                m_wreq, m_mreq;
  logic              exp_we, exp_ready, exp_stall, exp_busy;
  logic [ADDR_W-1:0] exp_rd;
  logic [XLEN-1:0]   exp_data;
  logic [XLEN-1:0]   exp_rf [32];
  logic [XLEN-1:0]   act_rf [32];
  logic [ADDR_W+XLEN-1:0] exp_q [$];

  task automatic model_reset();
    losses = 0;
    forced = 1'b0;
    init_left = INIT_CYCLES;
  endtask

  // Expected outputs for the current inputs.
  task automatic model_eval();
    m_wreq = wb_valid && (wb_rd != 0);
    m_mreq = mdu_valid && (mdu_rd != 0);
    exp_we = 1'b0; exp_rd = '0; exp_data = '0;
    exp_ready = 1'b0; exp_stall = 1'b0; exp_busy = 1'b0;
    if (init_left > 0) begin
      exp_we = 1'b1; exp_rd = ADDR_W'(32 - init_left); exp_data = '0;
      exp_busy = 1'b1; exp_stall = wb_valid;
    end else if (forced) begin
      exp_stall = wb_valid; exp_ready = 1'b1;
      exp_we = m_mreq; exp_rd = mdu_rd; exp_data = mdu_data;
    end else if (m_wreq) begin
      exp_we = 1'b1; exp_rd = wb_rd; exp_data = wb_data;
      exp_ready = !mdu_valid || (mdu_rd == 0);
    end else begin
      exp_we = m_mreq; exp_rd = mdu_rd; exp_data = mdu_data; exp_ready = 1'b1;
    end
  endtask

  // Driver: apply inputs just after the falling edge, then evaluate the model.
  task automatic set_in(input logic wv, input logic [ADDR_W-1:0] wr, input logic [XLEN-1:0] wd,
                        input logic mv, input logic [ADDR_W-1:0] mr, input logic [XLEN-1:0] md);
    @(negedge clk);
    wb_valid = wv; wb_rd = wr; wb_data = wd;
    mdu_valid = mv; mdu_rd = mr; mdu_data = md;
    #1;
    model_eval();
  endtask

  // Commit this cycle into the model and shadow files, then take the edge.
  task automatic tick();
    if (RegWrite === 1'b1) act_rf[rd] = write_data;
    if (exp_we) exp_rf[exp_rd] = exp_data;
    if (init_left > 0) init_left--;
    else if (forced) begin
      forced = 1'b0; losses = 0;
    end else if (m_wreq && m_mreq) begin
      losses++;
      if (losses >= MAX_WAIT) begin forced = 1'b1; losses = 0; end
    end else if (mdu_valid && exp_ready) losses = 0;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wb_valid = 1'b0; mdu_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < INIT_CYCLES; i++) begin
      set_in(1'b0, '0, '0, 1'b0, '0, '0);
      tick();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd5; mdu_valid = 1'b1; mdu_rd = 5'd3;
    #1;
    tests_run++;
    if (RegWrite !== 1'b0 || mdu_ready !== 1'b0 || wb_stall !== 1'b0 || busy_init !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: we=%b rdy=%b stall=%b busy=%b, required all 0",
               RegWrite, mdu_ready, wb_stall, busy_init);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    tests_run++;
    if (RegWrite !== exp_we || busy_init !== exp_busy || (exp_we && rd !== exp_rd)) begin
      tests_failed++;
      $display("FAIL reset_first_cycle: we=%b busy=%b rd=%0d, required we=%b busy=%b rd=%0d",
               RegWrite, busy_init, rd, exp_we, exp_busy, exp_rd);
    end
    tick();
    for (int i = 1; i < INIT_CYCLES; i++) begin
      set_in(1'b0, '0, '0, 1'b0, '0, '0);
      tick();
    end
  endtask

  task automatic test_wb_only();
    set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    tests_run++;
    if (RegWrite !== 1'b1 || rd !== 5'd5 || write_data !== 32'hDEADBEEF ||
        mdu_ready !== 1'b1 || wb_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL wb_only: we=%b rd=%0d data=%h rdy=%b stall=%b, required 1 5 deadbeef 1 0",
               RegWrite, rd, write_data, mdu_ready, wb_stall);
    end
    tick();
  endtask

  // Two losses, then an MDU handshake which must clear the loss count.
  task automatic test_mdu_only();
    for (int c = 0; c < 2; c++) begin
      set_in(1'b1, 5'd5, 32'h55, 1'b1, 5'd7, 32'h12);
      tests_run++;
      if (RegWrite !== 1'b1 || rd !== 5'd5 || mdu_ready !== 1'b0 || wb_stall !== 1'b0) begin
        tests_failed++;
        $display("FAIL mdu_loss_%0d: we=%b rd=%0d rdy=%b stall=%b, required 1 5 0 0",
                 c, RegWrite, rd, mdu_ready, wb_stall);
      end
      tick();
    end
    set_in(1'b0, '0, '0, 1'b1, 5'd7, 32'h12);
    tests_run++;
    if (RegWrite !== 1'b1 || rd !== 5'd7 || write_data !== 32'h12 || mdu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mdu_only: we=%b rd=%0d data=%h rdy=%b, required 1 7 12 1",
               RegWrite, rd, write_data, mdu_ready);
    end
    tick();
  endtask

  task automatic test_contention();
    for (int c = 1; c <= MAX_WAIT; c++) begin
      set_in(1'b1, ADDR_W'(10 + c), XLEN'(c), 1'b1, 5'd9, 32'h99);
      tests_run++;
      if (RegWrite !== 1'b1 || rd !== ADDR_W'(10 + c) || mdu_ready !== 1'b0 || wb_stall !== 1'b0) begin
        tests_failed++;
        $display("FAIL contention_wb_%0d: we=%b rd=%0d rdy=%b stall=%b, required 1 %0d 0 0",
                 c, RegWrite, rd, mdu_ready, wb_stall, 10 + c);
      end
      tick();
    end
    set_in(1'b1, 5'd15, 32'h5, 1'b1, 5'd9, 32'h99);
    tests_run++;
    if (wb_stall !== 1'b1 || RegWrite !== 1'b1 || rd !== 5'd9 || write_data !== 32'h99 ||
        mdu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL contention_starve: stall=%b we=%b rd=%0d data=%h rdy=%b, required 1 1 9 99 1",
               wb_stall, RegWrite, rd, write_data, mdu_ready);
    end
    tick();
    set_in(1'b1, 5'd15, 32'h5, 1'b0, '0, '0);
    tests_run++;
    if (wb_stall !== 1'b0 || RegWrite !== 1'b1 || rd !== 5'd15 || write_data !== 32'h5) begin
      tests_failed++;
      $display("FAIL contention_resume: stall=%b we=%b rd=%0d data=%h, required 0 1 15 5",
               wb_stall, RegWrite, rd, write_data);
    end
    tick();
  endtask

  task automatic test_starve_drop();
    for (int c = 0; c < MAX_WAIT; c++) begin
      set_in(1'b1, 5'd20, 32'h20, 1'b1, 5'd9, 32'h77);
      tick();
    end
    set_in(1'b1, 5'd21, 32'h21, 1'b0, 5'd9, 32'h77);
    tests_run++;
    if (wb_stall !== 1'b1 || RegWrite !== 1'b0 || mdu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL starve_drop: stall=%b we=%b rdy=%b, required 1 0 1", wb_stall, RegWrite, mdu_ready);
    end
    tick();
    set_in(1'b1, 5'd21, 32'h21, 1'b0, '0, '0);
    tests_run++;
    if (wb_stall !== 1'b0 || RegWrite !== 1'b1 || rd !== 5'd21) begin
      tests_failed++;
      $display("FAIL starve_drop_resume: stall=%b we=%b rd=%0d, required 0 1 21", wb_stall, RegWrite, rd);
    end
    tick();
  endtask

  task automatic test_x0();
    set_in(1'b1, 5'd0, 32'h1, 1'b1, 5'd3, 32'h33);
    tests_run++;
    if (RegWrite !== 1'b1 || rd !== 5'd3 || write_data !== 32'h33 || mdu_ready !== 1'b1 ||
        wb_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL x0_wb: we=%b rd=%0d data=%h rdy=%b stall=%b, required 1 3 33 1 0",
               RegWrite, rd, write_data, mdu_ready, wb_stall);
    end
    tick();
    set_in(1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 32'h9);
    tests_run++;
    if (RegWrite !== 1'b1 || rd !== 5'd4 || write_data !== 32'h44 || mdu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL x0_mdu: we=%b rd=%0d data=%h rdy=%b, required 1 4 44 1",
               RegWrite, rd, write_data, mdu_ready);
    end
    tick();
    set_in(1'b0, 5'd0, 32'h1, 1'b1, 5'd0, 32'h9);
    tests_run++;
    if (RegWrite !== 1'b0 || mdu_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL x0_only: we=%b rdy=%b, required 0 1", RegWrite, mdu_ready);
    end
    tick();
  endtask

  task automatic test_same_rd();
    logic [ADDR_W+XLEN-1:0] got, want;
    exp_q.delete();
    exp_q.push_back({5'd6, 32'hA});
    exp_q.push_back({5'd6, 32'hB});
    for (int c = 0; c < 2; c++) begin
      if (c == 0) set_in(1'b1, 5'd6, 32'hA, 1'b1, 5'd6, 32'hB);
      else        set_in(1'b0, 5'd6, 32'hA, 1'b1, 5'd6, 32'hB);
      got = {rd, write_data};
      want = exp_q.pop_front();
      tests_run++;
      if (RegWrite !== 1'b1 || got !== want) begin
        tests_failed++;
        $display("FAIL same_rd_write_%0d: we=%b rd/data=%h, required 1 %h", c, RegWrite, got, want);
      end
      tick();
    end
    tests_run++;
    if (act_rf[6] !== 32'hB) begin
      tests_failed++;
      $display("FAIL same_rd_final: x6=%h, required 0000000b", act_rf[6]);
    end
  endtask

  task automatic test_reset_mid_starve();
    for (int c = 0; c < MAX_WAIT; c++) begin
      set_in(1'b1, 5'd22, 32'h22, 1'b1, 5'd9, 32'h1);
      tick();
    end
    do_reset();
    for (int c = 1; c <= MAX_WAIT; c++) begin
      set_in(1'b1, 5'd23, 32'h23, 1'b1, 5'd9, 32'h1);
      tests_run++;
      if (wb_stall !== 1'b0 || RegWrite !== 1'b1 || rd !== 5'd23) begin
        tests_failed++;
        $display("FAIL reset_mid_starve_%0d: stall=%b we=%b rd=%0d, required 0 1 23",
                 c, wb_stall, RegWrite, rd);
      end
      tick();
    end
    set_in(1'b0, '0, '0, 1'b1, 5'd9, 32'h1);
    tick();
  endtask

  task automatic test_random();
    logic              wv, mv, st, hs, pend;
    logic [ADDR_W-1:0] wr, mr;
    logic [XLEN-1:0]   wd, md;
    do_reset();
    for (int i = 0; i < 32; i++) begin exp_rf[i] = '0; act_rf[i] = '0; end
    wv = 1'b0; wr = '0; wd = '0; mv = 1'b0; mr = '0; md = '0; st = 1'b0; pend = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (!st) begin
        wv = ($urandom_range(0, 9) < 7);
        wr = ADDR_W'($urandom_range(0, 7));
        wd = $urandom;
      end
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        mr = ADDR_W'($urandom_range(0, 7));
        md = $urandom;
      end
      mv = pend;
      set_in(wv, wr, wd, mv, mr, md);
      tests_run++;
      if (RegWrite !== exp_we || wb_stall !== exp_stall || mdu_ready !== exp_ready ||
          busy_init !== exp_busy || (exp_we && (rd !== exp_rd || write_data !== exp_data))) begin
        tests_failed++;
        $display("FAIL random_cyc_%0d: we=%b rd=%0d data=%h rdy=%b stall=%b busy=%b, required %b %0d %h %b %b %b",
                 cyc, RegWrite, rd, write_data, mdu_ready, wb_stall, busy_init,
                 exp_we, exp_rd, exp_data, exp_ready, exp_stall, exp_busy);
      end
      st = wb_stall;
      hs = mdu_valid && mdu_ready;
      tick();
      if (hs) pend = 1'b0;
    end
    for (int r = 1; r < 8; r++) begin
      tests_run++;
      if (act_rf[r] !== exp_rf[r]) begin
        tests_failed++;
        $display("FAIL random_regfile_x%0d: got %h, required %h", r, act_rf[r], exp_rf[r]);
      end
    end
  endtask

`ifdef REGFILE_INIT_EN
  task automatic test_init();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 5'd5, 32'h5, 1'b1, 5'd7, 32'h7);
      tests_run++;
      if (busy_init !== 1'b1 || RegWrite !== 1'b1 || rd !== ADDR_W'(i + 1) || write_data !== '0 ||
          wb_stall !== 1'b1 || mdu_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL init_partial_%0d: busy=%b we=%b rd=%0d data=%h stall=%b rdy=%b",
                 i, busy_init, RegWrite, rd, write_data, wb_stall, mdu_ready);
      end
      tick();
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 31; i++) begin
      set_in(1'b0, '0, '0, 1'b0, '0, '0);
      tests_run++;
      if (busy_init !== 1'b1 || RegWrite !== 1'b1 || rd !== ADDR_W'(i + 1) || write_data !== '0) begin
        tests_failed++;
        $display("FAIL init_sweep_%0d: busy=%b we=%b rd=%0d data=%h, required 1 1 %0d 0",
                 i, busy_init, RegWrite, rd, write_data, i + 1);
      end
      tick();
    end
    set_in(1'b0, '0, '0, 1'b0, '0, '0);
    tests_run++;
    if (busy_init !== 1'b0 || RegWrite !== 1'b0) begin
      tests_failed++;
      $display("FAIL init_done: busy=%b we=%b, required 0 0", busy_init, RegWrite);
    end
    tick();
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_wb_only();
    test_mdu_only();
    test_contention();
    test_starve_drop();
    test_x0();
    test_same_rd();
    test_reset_mid_starve();
`ifdef REGFILE_INIT_EN
    test_init();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
